// File: rtl/debounce_pulse_if.sv
// Button debouncer bundle: raw input toward the debouncer, clean level,
// edge pulses and busy flag back toward the consumer.
interface debounce_pulse_if;
  logic btn_in;
  logic btn_level;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  btn_level,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/debounce_pulse.sv
// Debouncer: N-flop synchronizer followed by a 4-state qualification FSM
// that accepts a level change only after STABLE_CYCLES identical samples.
module debounce_pulse #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic             clk,
  input  logic             reset,
  debounce_pulse_if.slave  bif
);

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_WIDTH;
  localparam longint unsigned STABLE_L = 64'(STABLE_CYCLES);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_chk_stable
    $error("STABLE_CYCLES must be >= 2");
  end
  if (CNT_SPAN < STABLE_L) begin : g_chk_cnt
    $error("CNT_WIDTH too small for STABLE_CYCLES");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bif.btn_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_WIDTH'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_WIDTH'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    // busy reflects where the FSM lands, so it lines up with state_q next cycle
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign bif.btn_level  = level_q;
  assign bif.rise_pulse = rise_q;
  assign bif.fall_pulse = fall_q;
  assign bif.busy       = busy_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: directed latency/glitch/reset cases plus
// randomized bouncing input checked every cycle against a run-length model.
module tb_debounce_pulse;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  debounce_pulse_if bif ();

  debounce_pulse #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_WIDTH    (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bif  (bif)
  );

  initial forever #5 clk = ~clk;

  // downstream D flip-flop stage with d tied high, enabled by rise_pulse
  logic q_dff;
  always @(posedge clk) begin
    if (reset) q_dff <= 1'b0;
    else if (bif.rise_pulse) q_dff <= 1'b1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: s is btn_in delayed SYNC edges; a change is accepted when the
  // run of samples differing from the current level reaches STABLE.
  logic m_lvl = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  logic m_busy = 1'b0;
  int   m_run = 0;
  logic m_pipe[$];
  bit   m_on = 1'b0;

  initial begin
    logic s;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pipe = {};
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
        m_lvl = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_busy = 1'b0; m_run = 0; m_on = 1'b1;
      end else if (m_on) begin
        s = m_pipe.pop_front();
        m_pipe.push_back(bif.btn_in);
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run = (s != m_lvl) ? m_run + 1 : 0;
        if (m_run == STABLE) begin
          m_lvl = s;
          m_rise = s;
          m_fall = !s;
          m_run = 0;
        end
        m_busy = (m_run != 0);
      end
      #1;
      if (m_on) begin
        vectors++;
        if ({bif.btn_level, bif.rise_pulse, bif.fall_pulse, bif.busy} !==
            {m_lvl, m_rise, m_fall, m_busy}) begin
          miscompares++;
          $display("FAIL model lvl/rise/fall/busy: got %b%b%b%b, want %b%b%b%b at %0t",
                   bif.btn_level, bif.rise_pulse, bif.fall_pulse, bif.busy,
                   m_lvl, m_rise, m_fall, m_busy, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves us just after cycle 0
  task automatic do_reset();
    reset = 1'b1;
    bif.btn_in = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int n_rise;
    int run_len;
    bif.btn_in = 1'b0;
    do_reset();
    check("reset level", bif.btn_level, 0);
    check("reset busy", bif.busy, 0);
    check("reset rise", bif.rise_pulse, 0);

    // clean press, then clean release
    bif.btn_in = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("t1 rise c%0d", c), bif.rise_pulse, int'(c == 6));
      check($sformatf("t1 level c%0d", c), bif.btn_level, int'(c >= 6));
      check($sformatf("t1 busy c%0d", c), bif.busy, int'(c >= 3 && c <= 5));
      check($sformatf("t6 q c%0d", c), q_dff, int'(c >= 7));
    end
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("t4 fall c%0d", c), bif.fall_pulse, int'(c == 6));
      check($sformatf("t4 level c%0d", c), bif.btn_level, int'(c < 6));
    end

    // too-short press
    do_reset();
    bif.btn_in = 1'b1;
    repeat (3) step();
    bif.btn_in = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("t2 level c%0d", c), bif.btn_level, 0);
      check($sformatf("t2 rise c%0d", c), bif.rise_pulse, 0);
      check($sformatf("t6 glitch q c%0d", c), q_dff, 0);
    end
    check("t2 busy end", bif.busy, 0);

    // bounce 1,0,1,0,1 then steady
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bif.btn_in = (i % 2 == 0);
      step();
    end
    bif.btn_in = 1'b1;
    n_rise = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("t3 rise c%0d", c), bif.rise_pulse, int'(c == 6));
      n_rise += int'(bif.rise_pulse);
    end
    check("t3 rise count", n_rise, 1);

    // reset mid-qualification with button held
    do_reset();
    bif.btn_in = 1'b1;
    repeat (4) step();
    check("t5 busy before reset", bif.busy, 1);
    reset = 1'b1;
    step();
    check("t5 level in reset", bif.btn_level, 0);
    check("t5 busy in reset", bif.busy, 0);
    check("t5 rise in reset", bif.rise_pulse, 0);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("t5 rise c%0d", c), bif.rise_pulse, int'(c == 6));
    end

    // random bouncing, model-checked every cycle
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k % 16 == 0) begin
        bif.btn_in = 1'($urandom_range(0, 1));
        run_len = ($urandom_range(0, 3) == 0) ? 12 : 1;
      end else if (run_len <= 1 || $urandom_range(0, 5) == 0) begin
        bif.btn_in = 1'($urandom_range(0, 1));
        run_len = 1 + $urandom_range(0, 7);
      end else begin
        run_len--;
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
